syn_ram_master: RTL and testbench

Initiator for the single-port synchronous RAM (`syn_ram`: din/addr/w_en in, registered dout out). It accepts burst commands over a valid/ready handshake and drives the RAM port. Write data is sourced from a streaming input; read data is returned on a streaming output with backpressure. Sits between a client (DMA/host logic) and syn_ram, replacing ad-hoc direct drive of w_en/addr.

---
 rtl/syn_ram_pkg.sv | 22 ++
 rtl/syn_ram_if.sv | 34 +++
 rtl/syn_ram_master_skid.sv | 43 ++++
 rtl/syn_ram_master.sv | 143 ++++++++++++++
 tb/tb_syn_ram_master.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/syn_ram_pkg.sv
// Shared types and defaults for the syn_ram initiator.
// Holds the FSM state encoding and the burst command layout.
package syn_ram_pkg;

   localparam int DEF_ADDR_W = 5;
   localparam int DEF_DATA_W = 8;
   localparam int DEPTH = 1 << DEF_ADDR_W;

   typedef enum logic [1:0] {
      IDLE,
      WRITE,
      READ,
      CLEAR
   } state_t;

   typedef struct packed {
      logic                  wr;
      logic [DEF_ADDR_W-1:0] addr;
      logic [DEF_ADDR_W-1:0] len;
   } cmd_t;

endpackage

// File: rtl/syn_ram_if.sv
// Client-side bundle of syn_ram_master: command,
// write-beat and read-beat valid/ready channels.
interface syn_ram_if
   import syn_ram_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
);

   logic              cmd_valid;
   logic              cmd_ready;
   logic              cmd_wr;
   logic [ADDR_W-1:0] cmd_addr;
   logic [ADDR_W-1:0] cmd_len;
   logic              wr_valid;
   logic              wr_ready;
   logic [DATA_W-1:0] wr_data;
   logic              rd_valid;
   logic              rd_ready;
   logic [DATA_W-1:0] rd_data;

   modport master (
      input  cmd_valid, cmd_wr, cmd_addr, cmd_len,
      input  wr_valid, wr_data, rd_ready,
      output cmd_ready, wr_ready, rd_valid, rd_data
   );

   modport slave (
      output cmd_valid, cmd_wr, cmd_addr, cmd_len,
      output wr_valid, wr_data, rd_ready,
      input  cmd_ready, wr_ready, rd_valid, rd_data
   );

endinterface

// File: rtl/syn_ram_master_skid.sv
// ram_rd_skid: 2-entry FIFO catching registered RAM
// read data so the read stream can absorb backpressure.
module ram_rd_skid
   import syn_ram_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   output logic              head_valid,
   output logic [DATA_W-1:0] head_data,
   output logic [1:0]        count
);

   logic [DATA_W-1:0] mem [2];
   logic              wp;
   logic              rp;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem[0] <= '0;
         mem[1] <= '0;
         wp     <= 1'b0;
         rp     <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push) begin
            mem[wp] <= push_data;
            wp      <= ~wp;
         end
         if (pop)
            rp <= ~rp;
         count <= count + {1'b0, push} - {1'b0, pop};
      end
   end

   assign head_valid = (count != 2'd0);
   assign head_data  = mem[rp];

endmodule

// File: rtl/syn_ram_master.sv
// Burst initiator for single-port syn_ram (write and read).
// Define RAM_CLEAR_EN to zero the whole RAM after reset.
module syn_ram_master
   import syn_ram_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic              clk,
   input  logic              rst_n,
   syn_ram_if.master         bus,
   output logic              busy,
   output logic [DATA_W-1:0] ram_din,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_w_en,
   input  logic [DATA_W-1:0] ram_dout
);

   localparam logic [ADDR_W:0] NLOC = {1'b1, {ADDR_W{1'b0}}};

   state_t            state, state_n;
   logic [ADDR_W-1:0] ptr, ptr_n;
   logic [ADDR_W:0]   rem, rem_n;
   logic              inflight, inflight_n;
   logic              cmd_rdy, wr_rdy, w_en;
   logic [DATA_W-1:0] din;
   logic              hv, pop;
   logic [DATA_W-1:0] hd;
   logic [1:0]        cnt;
   logic [2:0]        occ;
`ifdef RAM_CLEAR_EN
   logic              clr_pend, clr_pend_n;
`endif

   ram_rd_skid #(.DATA_W(DATA_W)) u_skid (
      .clk        (clk),
      .rst_n      (rst_n),
      .push       (inflight),
      .push_data  (ram_dout),
      .pop        (pop),
      .head_valid (hv),
      .head_data  (hd),
      .count      (cnt)
   );

   assign pop = hv & bus.rd_ready;
   // A pop this cycle frees a slot, keeping reads at 1 beat/cycle
   assign occ = {1'b0, cnt} + {2'b0, inflight} - {2'b0, pop};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         ptr      <= '0;
         rem      <= '0;
         inflight <= 1'b0;
`ifdef RAM_CLEAR_EN
         clr_pend <= 1'b1;
`endif
      end else begin
         state    <= state_n;
         ptr      <= ptr_n;
         rem      <= rem_n;
         inflight <= inflight_n;
`ifdef RAM_CLEAR_EN
         clr_pend <= clr_pend_n;
`endif
      end
   end

   always_comb begin
      state_n    = state;
      ptr_n      = ptr;
      rem_n      = rem;
      inflight_n = 1'b0;
      cmd_rdy    = 1'b0;
      wr_rdy     = 1'b0;
      w_en       = 1'b0;
      din        = '0;
`ifdef RAM_CLEAR_EN
      clr_pend_n = clr_pend;
`endif
      unique case (state)
         IDLE: begin
            cmd_rdy = 1'b1;
`ifdef RAM_CLEAR_EN
            cmd_rdy = !clr_pend;
            if (clr_pend) begin
               state_n    = CLEAR;
               ptr_n      = '0;
               rem_n      = NLOC;
               clr_pend_n = 1'b0;
            end
`endif
            if (cmd_rdy && bus.cmd_valid) begin
               ptr_n   = bus.cmd_addr;
               rem_n   = {1'b0, bus.cmd_len} + 1'b1;
               state_n = bus.cmd_wr ? WRITE : READ;
            end
         end
         WRITE: begin
            wr_rdy = 1'b1;
            w_en   = bus.wr_valid;
            din    = bus.wr_data;
            if (bus.wr_valid) begin
               ptr_n = ptr + 1'b1;
               rem_n = rem - 1'b1;
               if (rem == 1)
                  state_n = IDLE;
            end
         end
         READ: begin
            if (rem != 0 && occ < 3'd2) begin
               inflight_n = 1'b1;
               ptr_n      = ptr + 1'b1;
               rem_n      = rem - 1'b1;
            end
            if (rem == 0 && !inflight &&
                (cnt == 2'd0 || (cnt == 2'd1 && pop)))
               state_n = IDLE;
         end
`ifdef RAM_CLEAR_EN
         CLEAR: begin
            w_en  = 1'b1;
            ptr_n = ptr + 1'b1;
            rem_n = rem - 1'b1;
            if (rem == 1)
               state_n = IDLE;
         end
`endif
         default: state_n = IDLE;
      endcase
   end

   assign bus.cmd_ready = cmd_rdy;
   assign bus.wr_ready  = wr_rdy;
   assign bus.rd_valid  = hv;
   assign bus.rd_data   = hd;
   assign busy          = (state != IDLE);
   assign ram_w_en      = w_en;
   assign ram_din       = din;
   assign ram_addr      = ptr;

endmodule

// File: tb/tb_syn_ram_master.sv
// Directed bench for syn_ram_master against a behavioural
// syn_ram model; RAM_CLEAR_EN selects the clear-on-reset checks.
module tb_syn_ram_master;
   import syn_ram_pkg::*;

`ifdef RAM_CLEAR_EN
   localparam logic       RDY_RST   = 1'b0;
   localparam logic [7:0] AFTER_RST = 8'd0;
`else
   localparam logic       RDY_RST   = 1'b1;
   localparam logic [7:0] AFTER_RST = 8'd12;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       busy;
   logic       ram_w_en;
   logic [7:0] ram_din;
   logic [7:0] ram_dout;
   logic [4:0] ram_addr;
   logic [7:0] mem [32];

   int         checks = 0;
   int         fails = 0;
   logic [7:0] wq [$];
   logic [7:0] eq [$];
   logic [7:0] got [$];
   int         first_cyc;
   int         last_cyc;
   logic [4:0] hold_addr;
   int         beat;

   syn_ram_if bus ();

   syn_ram_master dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus),
      .busy     (busy),
      .ram_din  (ram_din),
      .ram_addr (ram_addr),
      .ram_w_en (ram_w_en),
      .ram_dout (ram_dout)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ram_w_en)
         mem[ram_addr] <= ram_din;
      ram_dout <= mem[ram_addr];
   end

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h",
                tag, obs, exp);
      end
   endtask

   task automatic do_write(input logic [4:0] a,
                           input logic [4:0] l,
                           input bit gap);
      int k = 0;
      logic [4:0] ea = a;
      bus.cmd_valid = 1'b1;
      bus.cmd_wr    = 1'b1;
      bus.cmd_addr  = a;
      bus.cmd_len   = l;
      chk("wr_cmd_ready", bus.cmd_ready, 1);
      for (int c = 1; c <= 40 && k <= int'(l); c++) begin
         @(negedge clk);
         bus.cmd_valid = 1'b0;
         bus.wr_valid  = !(gap && c == 2);
         bus.wr_data   = wq[k];
         #1;
         chk("wr_busy", busy, 1);
         chk("wr_ready", bus.wr_ready, 1);
         chk("wr_wen", ram_w_en, bus.wr_valid);
         if (bus.wr_valid) begin
            chk("wr_addr", ram_addr, ea);
            chk("wr_din", ram_din, wq[k]);
            k++;
            ea++;
         end
      end
      chk("wr_beats", k, int'(l) + 1);
      @(negedge clk);
      bus.wr_valid = 1'b0;
      #1;
      chk("wr_end_busy", busy, 0);
      chk("wr_end_rdy", bus.cmd_ready, 1);
      chk("wr_end_wen", ram_w_en, 0);
   endtask

   task automatic do_read(input logic [4:0] a,
                          input logic [4:0] l,
                          input int hold);
      int n = int'(l) + 1;
      got.delete();
      first_cyc = -1;
      last_cyc  = -1;
      hold_addr = '0;
      bus.cmd_valid = 1'b1;
      bus.cmd_wr    = 1'b0;
      bus.cmd_addr  = a;
      bus.cmd_len   = l;
      for (int c = 1; c <= 80 && got.size() < n; c++) begin
         @(negedge clk);
         bus.cmd_valid = 1'b0;
         bus.rd_ready  = (c > hold);
         #1;
         if (c == hold)
            hold_addr = ram_addr;
         if (bus.rd_valid && !bus.rd_ready)
            chk("rd_stall", bus.rd_data, eq[0]);
         if (bus.rd_valid && bus.rd_ready) begin
            got.push_back(bus.rd_data);
            if (first_cyc < 0)
               first_cyc = c;
            last_cyc = c;
         end
      end
      chk("rd_beats", got.size(), n);
      for (int k = 0; k < got.size(); k++)
         chk("rd_data", got[k], eq[k]);
      @(negedge clk);
      bus.rd_ready = 1'b0;
      #1;
      chk("rd_end_busy", busy, 0);
      chk("rd_end_valid", bus.rd_valid, 0);
      chk("rd_end_rdy", bus.cmd_ready, 1);
   endtask

   task automatic wait_ready();
      for (int c = 0; c < 60 && !bus.cmd_ready; c++) begin
         @(negedge clk);
         #1;
      end
      chk("ready_wait", bus.cmd_ready, 1);
   endtask

   initial begin
      bus.cmd_valid = 1'b0;
      bus.cmd_wr    = 1'b0;
      bus.cmd_addr  = '0;
      bus.cmd_len   = '0;
      bus.wr_valid  = 1'b0;
      bus.wr_data   = '0;
      bus.rd_ready  = 1'b0;

      repeat (2) @(negedge clk);
      #1;
      chk("rst_cmd_ready", bus.cmd_ready, RDY_RST);
      chk("rst_busy", busy, 0);
      chk("rst_wr_ready", bus.wr_ready, 0);
      chk("rst_rd_valid", bus.rd_valid, 0);
      chk("rst_rd_data", bus.rd_data, 0);
      chk("rst_wen", ram_w_en, 0);
      chk("rst_addr", ram_addr, 0);
      chk("rst_din", ram_din, 0);

      @(negedge clk);
      rst_n = 1'b1;
      #1;
`ifdef RAM_CLEAR_EN
      chk("clr_pend_rdy", bus.cmd_ready, 0);
      for (int i = 0; i < 32; i++) begin
         @(negedge clk);
         #1;
         chk("clr_wen", ram_w_en, 1);
         chk("clr_addr", ram_addr, i);
         chk("clr_din", ram_din, 0);
         chk("clr_rdy", bus.cmd_ready, 0);
         chk("clr_busy", busy, 1);
      end
      @(negedge clk);
      #1;
      chk("clr_done_rdy", bus.cmd_ready, 1);
      chk("clr_done_wen", ram_w_en, 0);
      eq.delete();
      repeat (32) eq.push_back(8'd0);
      do_read(5'd0, 5'd31, 0);
`endif
      wait_ready();

      // basic write then read, with latency check
      wq = '{8'd10, 8'd25};
      do_write(5'd1, 5'd1, 1'b0);
      eq = '{8'd10, 8'd25};
      do_read(5'd1, 5'd1, 0);
      chk("rd_latency", first_cyc, 3);

      // address wrap 30,31,0,1
      wq = '{8'd1, 8'd2, 8'd3, 8'd4};
      do_write(5'd30, 5'd3, 1'b0);
      eq = '{8'd1, 8'd2, 8'd3, 8'd4};
      do_read(5'd30, 5'd3, 0);
      chk("wrap_rate", last_cyc - first_cyc, 3);

      // backpressure: 5 cycles of rd_ready low
      do_read(5'd30, 5'd3, 5);
      chk("bp_issued", hold_addr, 5'd0);
      chk("bp_first", first_cyc, 6);
      chk("bp_rate", last_cyc - first_cyc, 3);

      // write stall pattern 1,0,1
      wq = '{8'd7, 8'd9};
      do_write(5'd5, 5'd1, 1'b1);
      eq = '{8'd7, 8'd9};
      do_read(5'd5, 5'd1, 0);

      // reset during beat 2 of an 8-beat read
      wq = '{8'd12};
      do_write(5'd3, 5'd0, 1'b0);
      bus.cmd_valid = 1'b1;
      bus.cmd_wr    = 1'b0;
      bus.cmd_addr  = 5'd0;
      bus.cmd_len   = 5'd7;
      beat = 0;
      for (int c = 1; c <= 40 && beat < 2; c++) begin
         @(negedge clk);
         bus.cmd_valid = 1'b0;
         bus.rd_ready  = 1'b1;
         #1;
         if (bus.rd_valid)
            beat++;
      end
      chk("mid_beats", beat, 2);
      rst_n = 1'b0;
      #1;
      chk("mid_rd_valid", bus.rd_valid, 0);
      chk("mid_wen", ram_w_en, 0);
      chk("mid_busy", busy, 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("post_rd_valid", bus.rd_valid, 0);
      wait_ready();
      chk("post_rd_valid2", bus.rd_valid, 0);
      bus.rd_ready = 1'b0;
      eq = '{AFTER_RST};
      do_read(5'd3, 5'd0, 0);

      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule
